// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte requesters.
// Optional packet lock (keep the grant until req_last) enabled by TX_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_valid_i,
  input  logic [8*N-1:0]   req_data_i,
  input  logic [N-1:0]     req_last_i,
  output logic [N-1:0]     req_ready_o,
  output logic [N-1:0]     gnt_o,
  output logic [7:0]       tx_data_o,
  output logic             tx_start_o,
  input  logic             tx_ready_i,
  output logic             busy_o,
  output logic [15:0]      byte_cnt_o
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_LO,
    S_WAIT_HI,
    S_HOLD
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   owner_q;
  logic [N-1:0]    req_ready_q;
  logic [N-1:0]    gnt_q;
  logic [7:0]      tx_data_q;
  logic            tx_start_q;
  logic            busy_q;
  logic [15:0]     byte_cnt_q;

  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic [IW:0]     scan_sum;
  logic [IW-1:0]   ptr_nxt;

`ifdef TX_ARB_LOCK_EN
  logic            last_q;
`else
  logic            unused_last;
  assign unused_last = ^req_last_i;
`endif

  // First valid requester scanning from ptr_q upward with wrap-around.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    scan_sum = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan_sum >= (IW+1)'(N)) begin
        scan_sum = scan_sum - (IW+1)'(N);
      end
      if (!pick_vld && req_valid_i[scan_sum[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = scan_sum[IW-1:0];
      end
    end
  end

  assign ptr_nxt = (owner_q == IW'(N-1)) ? '0 : owner_q + IW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      req_ready_q <= '0;
      gnt_q       <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      byte_cnt_q  <= '0;
`ifdef TX_ARB_LOCK_EN
      last_q      <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            req_ready_q <= N'(1) << pick_idx;
            gnt_q       <= N'(1) << pick_idx;
            tx_data_q   <= req_data_i[{pick_idx, 3'b000} +: 8];
            owner_q     <= pick_idx;
            busy_q      <= 1'b1;
            state_q     <= S_START;
`ifdef TX_ARB_LOCK_EN
            last_q      <= req_last_i[pick_idx];
`endif
          end
        end
        // The core may still be finishing a frame from before a reset.
        S_START: begin
          if (tx_ready_i) begin
            tx_start_q <= 1'b1;
            state_q    <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!tx_ready_i) begin
            state_q <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (tx_ready_i) begin
            byte_cnt_q <= byte_cnt_q + 16'd1;
`ifdef TX_ARB_LOCK_EN
            if (!last_q) begin
              state_q <= S_HOLD;
            end else begin
              ptr_q   <= ptr_nxt;
              gnt_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
`else
            ptr_q   <= ptr_nxt;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
`endif
          end
        end
`ifdef TX_ARB_LOCK_EN
        // Packet in progress: only the current owner may continue.
        S_HOLD: begin
          if (req_valid_i[owner_q]) begin
            req_ready_q <= gnt_q;
            tx_data_q   <= req_data_i[{owner_q, 3'b000} +: 8];
            last_q      <= req_last_i[owner_q];
            state_q     <= S_START;
          end
        end
`endif
        default: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign gnt_o       = gnt_q;
  assign tx_data_o   = tx_data_q;
  assign tx_start_o  = tx_start_q;
  assign busy_o      = busy_q;
  assign byte_cnt_o  = byte_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: randomized and directed requesters,
// a UART core model and a round-robin reference model (TX_ARB_LOCK_EN aware).
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int FRAME = 10;
`ifdef TX_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           force_v;
  logic [N-1:0]   req_v;
  logic [8*N-1:0] req_d;
  logic [N-1:0]   req_l;
  logic [N-1:0]   dut_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   gnt;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_ready;
  logic           busy;
  logic [15:0]    byte_cnt;

  assign dut_valid = req_v | {N{force_v}};

  uart_tx_arbiter #(.N(N)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(dut_valid), .req_data_i(req_d),
    .req_last_i(req_l), .req_ready_o(req_ready), .gnt_o(gnt), .tx_data_o(tx_data),
    .tx_start_o(tx_start), .tx_ready_i(tx_ready), .busy_o(busy), .byte_cnt_o(byte_cnt)
  );

  typedef struct {
    int         idx;
    logic [7:0] d;
    logic       l;
  } item_t;

  item_t      pend[$];
  logic [7:0] start_q[$];
  int         acc_rec[$];
  logic [7:0] cur_d[N];
  logic       cur_l[N];
  int         rise_cyc[N];

  int checks = 0;
  int errors = 0;
  int m_ptr, m_lock_w, starts_rst, start_total, acc_total, acc_cyc, start_cyc, frame_cnt, cyc;
  bit m_locked, awaiting, prst, ptxr, pawait, rand_en, core_hold;
  logic [N-1:0] pv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit has_pend(input int i);
    foreach (pend[j]) if (pend[j].idx == i) return 1'b1;
    return 1'b0;
  endfunction

  // Requesters, core model and monitor all act on the falling edge.
  initial begin
    int w, ew;
    bit exp_start;
    item_t it;
    prst = 1'b1; ptxr = 1'b1; pawait = 1'b0; pv = '0; frame_cnt = 0; cyc = 0;
    req_v = '0; req_d = '0; req_l = '0; tx_ready = 1'b1;
    m_ptr = 0; m_locked = 1'b0; m_lock_w = 0; awaiting = 1'b0;
    starts_rst = 0; start_total = 0; acc_total = 0; acc_cyc = 0; start_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      w = -1;
      if (prst) begin
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_byte_cnt", 32'(byte_cnt), 0);
        m_ptr = 0; m_locked = 1'b0; awaiting = 1'b0; start_q.delete(); starts_rst = 0;
      end else begin
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 1);
        if (req_ready != '0) begin
          chk("ready_onehot", 32'($countones(req_ready)), 1);
          for (int k = 0; k < N; k++) if (req_ready[k]) w = k;
          if (m_locked) ew = pv[m_lock_w] ? m_lock_w : -1;
          else ew = rr_pick(pv, m_ptr);
          chk("grant_idx", 32'(w), 32'(ew));
          chk("gnt_owner", 32'(gnt), 32'(req_ready));
          chk("accept_data", 32'(tx_data), 32'(cur_d[w]));
          chk("busy_on_accept", 32'(busy), 1);
          start_q.push_back(cur_d[w]);
          acc_rec.push_back(w);
          acc_cyc = cyc;
          acc_total++;
          if (LOCK && !cur_l[w]) begin
            m_locked = 1'b1; m_lock_w = w;
          end else begin
            m_locked = 1'b0; m_ptr = (w + 1) % N;
          end
        end
        exp_start = pawait && ptxr;
        if (tx_start || exp_start) chk("tx_start", 32'(tx_start), 32'(exp_start));
        if (tx_start) begin
          if (start_q.size() == 0) chk("start_without_accept", 1, 0);
          else chk("start_data", 32'(tx_data), 32'(start_q.pop_front()));
          starts_rst++; start_total++; start_cyc = cyc;
        end
        awaiting = (awaiting && !tx_start) || (w >= 0);
      end
      pawait = awaiting;

      if (tx_start) frame_cnt = FRAME;
      else if (frame_cnt > 0) frame_cnt--;
      tx_ready = (frame_cnt == 0) && !core_hold;

      if (w >= 0) req_v[w] = 1'b0;
      if (LOCK && m_locked && !rand_en && !req_v[m_lock_w] && !has_pend(m_lock_w)) begin
        it.idx = m_lock_w; it.d = 8'($urandom); it.l = 1'b1;
        pend.push_back(it);
      end
      if (rand_en && pend.size() < 6 && $urandom_range(0, 2) == 0) begin
        it.idx = int'($urandom_range(0, N-1)); it.d = 8'($urandom); it.l = 1'($urandom_range(0, 1));
        pend.push_back(it);
      end
      for (int j = 0; j < pend.size(); j++) begin
        if (!req_v[pend[j].idx]) begin
          req_v[pend[j].idx] = 1'b1;
          req_d[8*pend[j].idx +: 8] = pend[j].d;
          req_l[pend[j].idx] = pend[j].l;
          cur_d[pend[j].idx] = pend[j].d;
          cur_l[pend[j].idx] = pend[j].l;
          rise_cyc[pend[j].idx] = cyc;
          pend.delete(j);
          j--;
        end
      end
      pv = req_v | {N{force_v}};
      prst = rst;
      ptxr = tx_ready;
    end
  end

  task automatic push(input int i, input logic [7:0] d, input logic l);
    item_t it;
    it.idx = i; it.d = d; it.l = l;
    pend.push_back(it);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    int q, n;
    q = 0; n = 0;
    while (q < 4 && n < budget) begin
      @(negedge clk); #1;
      n++;
      if (pend.size() == 0 && req_v == '0 && !awaiting && frame_cnt == 0 && !busy) q++;
      else q = 0;
    end
    chk("quiet_timeout", 32'(q >= 4), 1);
  endtask

  initial begin
    int sa, aa, n;
    int exp3[5];
    int exp6[$];
    rst = 1'b1; force_v = 1'b1; core_hold = 1'b0; rand_en = 1'b0;
    exp3 = '{0, 1, 2, 3, 0};
    repeat (2) @(posedge clk);
    #2 rst = 1'b0; force_v = 1'b0;
    @(negedge clk); #1;
    chk("idle_after_reset", 32'(busy), 0);

    // Single byte: latency and count.
    @(posedge clk); #2 push(0, 8'h43, 1'b1);
    wait_quiet(200);
    chk("accept_latency", 32'(acc_cyc - rise_cyc[0]), 1);
    chk("start_latency", 32'(start_cyc - rise_cyc[0]), 2);
    chk("byte_cnt_one", 32'(byte_cnt), 1);

    // All four requesting: fair rotation.
    do_reset();
    acc_rec.delete();
    for (int i = 0; i < 5; i++) push(exp3[i], 8'($urandom), 1'b1);
    wait_quiet(400);
    chk("rr_count", 32'(acc_rec.size()), 5);
    for (int i = 0; i < 5 && i < acc_rec.size(); i++) chk("rr_order", 32'(acc_rec[i]), 32'(exp3[i]));
    chk("byte_cnt_five", 32'(byte_cnt), 5);

    // Core busy at request time: accept but withhold start.
    @(posedge clk); #2 core_hold = 1'b1;
    sa = start_total; aa = acc_total;
    push(2, 8'hA5, 1'b1);
    repeat (8) @(negedge clk);
    #1;
    chk("hold_accepted", 32'(acc_total), 32'(aa + 1));
    chk("hold_no_start", 32'(start_total), 32'(sa));
    @(posedge clk); #2 core_hold = 1'b0;
    wait_quiet(200);
    chk("hold_one_start", 32'(start_total), 32'(sa + 1));

    // Reset while waiting for frame end.
    sa = start_total;
    push(1, 8'h5A, 1'b1);
    n = 0;
    while (start_total == sa && n < 50) begin @(negedge clk); #1; n++; end
    chk("start_before_reset", 32'(start_total), 32'(sa + 1));
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    push(3, 8'h3C, 1'b1);
    wait_quiet(300);
    chk("byte_cnt_after_reset", 32'(byte_cnt), 1);

    // Packet lock versus per-byte re-arbitration.
    do_reset();
    acc_rec.delete();
    if (LOCK) begin
      push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1); push(1, 8'h20, 1'b1);
      exp6 = '{0, 0, 0, 1};
    end else begin
      push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1);
      push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b1);
      exp6 = '{0, 1, 0, 1, 0};
    end
    wait_quiet(400);
    chk("pkt_count", 32'(acc_rec.size()), 32'(exp6.size()));
    for (int i = 0; i < exp6.size() && i < acc_rec.size(); i++) chk("pkt_order", 32'(acc_rec[i]), 32'(exp6[i]));

    // Random traffic.
    @(posedge clk); #2 rand_en = 1'b1;
    repeat (1500) @(posedge clk);
    #2 rand_en = 1'b0;
    wait_quiet(3000);
    chk("rand_byte_cnt", 32'(byte_cnt), 32'(16'(starts_rst)));
    chk("accepts_vs_starts", 32'(acc_total), 32'(start_total));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
